// File: rtl/key_pkg.sv
// Shared definitions for the key handling blocks: FSM state encoding and
// default timing constants used by every key_* module.
package key_pkg;

    localparam int DEB_CNT_DEF    = 15;
    localparam int LONG_CNT_DEF   = 200;
    localparam int REPEAT_CNT_DEF = 50;
    localparam int CNT_W_DEF      = 8;
    localparam int SYNC_STAGES    = 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_DEB = 3'd1,
        HELD      = 3'd2,
        LONG_HELD = 3'd3,
        REL_DEB   = 3'd4
    } key_state_t;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'd0,
        EV_RELEASE = 2'd1,
        EV_LONG    = 2'd2,
        EV_REPEAT  = 2'd3
    } key_ev_t;

endpackage

// File: rtl/key_event_if.sv
// Key pin and event bundle between the board key and the setting controllers.
// master: the event generator; slave: the key source / event consumer.
interface key_event_if;

    logic key_in;
    logic key_press;
    logic key_release;
    logic key_long;
    logic key_repeat;
    logic key_held;

    modport master (
        input  key_in,
        output key_press,
        output key_release,
        output key_long,
        output key_repeat,
        output key_held
    );

    modport slave (
        output key_in,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_repeat,
        input  key_held
    );

endinterface

// File: rtl/key_sync.sv
// Multi-flop synchronizer for the asynchronous key pin; resets to the
// released (high) level so a reset never looks like a press.
module key_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/key_event.sv
// Debounced press/release detector with long-press and auto-repeat pulses.
// All outputs are registered; pulses last exactly one clock.
module key_event
    import key_pkg::*;
#(
    parameter int DEB_CNT    = DEB_CNT_DEF,
    parameter int LONG_CNT   = LONG_CNT_DEF,
    parameter int REPEAT_CNT = REPEAT_CNT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic        key_clk,
    input  logic        key_rst,
    key_event_if.master keys
);

    // Terminal values: the transition fires on the cycle the count would reach N.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);

    logic s;

    key_state_t       state_reg;
    logic [CNT_W-1:0] deb_reg;
    logic [CNT_W-1:0] hold_reg;
    logic [CNT_W-1:0] rep_reg;
    logic [CNT_W-1:0] rel_reg;
    logic             lng_reg;
    logic             press_reg;
    logic             release_reg;
    logic             long_reg;
    logic             repeat_reg;
    logic             held_reg;

    key_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (key_clk),
        .srst (key_rst),
        .d    (keys.key_in),
        .q    (s)
    );

    always_ff @(posedge key_clk) begin
        if (key_rst) begin
            state_reg   <= IDLE;
            deb_reg     <= '0;
            hold_reg    <= '0;
            rep_reg     <= '0;
            rel_reg     <= '0;
            lng_reg     <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            long_reg    <= 1'b0;
            repeat_reg  <= 1'b0;
            held_reg    <= 1'b0;
        end else begin
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            long_reg    <= 1'b0;
            repeat_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (!s) begin
                        state_reg <= PRESS_DEB;
                        deb_reg   <= CNT_W'(1);
                    end
                end

                PRESS_DEB: begin
                    if (s) begin
                        state_reg <= IDLE;
                        deb_reg   <= '0;
                    end else if (deb_reg == DEB_LAST) begin
                        press_reg <= 1'b1;
                        held_reg  <= 1'b1;
                        state_reg <= HELD;
                        hold_reg  <= '0;
                        deb_reg   <= '0;
                    end else begin
                        deb_reg <= deb_reg + 1'b1;
                    end
                end

                HELD: begin
                    if (s) begin
                        state_reg <= REL_DEB;
                        rel_reg   <= CNT_W'(1);
                        lng_reg   <= 1'b0;
                    end else if (hold_reg == LONG_LAST) begin
                        long_reg  <= 1'b1;
                        state_reg <= LONG_HELD;
                        hold_reg  <= '0;
                        rep_reg   <= '0;
                    end else begin
                        hold_reg <= hold_reg + 1'b1;
                    end
                end

                LONG_HELD: begin
                    if (s) begin
                        state_reg <= REL_DEB;
                        rel_reg   <= CNT_W'(1);
                        lng_reg   <= 1'b1;
                    end else if (rep_reg == REP_LAST) begin
                        repeat_reg <= 1'b1;
                        rep_reg    <= '0;
                    end else begin
                        rep_reg <= rep_reg + 1'b1;
                    end
                end

                REL_DEB: begin
                    if (s) begin
                        if (rel_reg == DEB_LAST) begin
                            release_reg <= 1'b1;
                            held_reg    <= 1'b0;
                            state_reg   <= IDLE;
                            rel_reg     <= '0;
                            hold_reg    <= '0;
                            rep_reg     <= '0;
                            lng_reg     <= 1'b0;
                        end else begin
                            rel_reg <= rel_reg + 1'b1;
                        end
                    end else begin
                        // Release bounce: resume the hold, counting this low sample.
                        rel_reg <= '0;
                        if (lng_reg) begin
                            state_reg <= LONG_HELD;
                            if (rep_reg == REP_LAST) begin
                                repeat_reg <= 1'b1;
                                rep_reg    <= '0;
                            end else begin
                                rep_reg <= rep_reg + 1'b1;
                            end
                        end else if (hold_reg == LONG_LAST) begin
                            long_reg  <= 1'b1;
                            state_reg <= LONG_HELD;
                            hold_reg  <= '0;
                            rep_reg   <= '0;
                        end else begin
                            state_reg <= HELD;
                            hold_reg  <= hold_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    deb_reg   <= '0;
                    hold_reg  <= '0;
                    rep_reg   <= '0;
                    rel_reg   <= '0;
                    lng_reg   <= 1'b0;
                    held_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign keys.key_press   = press_reg;
    assign keys.key_release = release_reg;
    assign keys.key_long    = long_reg;
    assign keys.key_repeat  = repeat_reg;
    assign keys.key_held    = held_reg;

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: expected pulses are queued with their cycle
// when stimulus is driven and matched by a monitor as the DUT emits them.
module tb_key_event;

    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 8;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    logic clk;
    logic rst;
    int   cyc;
    int   vectors;
    int   miscompares;
    ev_t  sb[$];
    int   p1, r1, p2, r2;
    int   t0;

    key_event_if kif ();

    key_event #(
        .DEB_CNT    (DEB),
        .LONG_CNT   (LNG),
        .REPEAT_CNT (REP),
        .CNT_W      (8)
    ) dut (
        .key_clk (clk),
        .key_rst (rst),
        .keys    (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int kind, input int when);
        ev_t e;
        e.kind = kind;
        e.at   = when;
        sb.push_back(e);
    endtask

    task automatic held_windows(input int a1, input int b1, input int a2, input int b2);
        p1 = a1; r1 = b1; p2 = a2; r2 = b2;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_press"},   int'(kif.key_press),   0);
        check({tag, "_release"}, int'(kif.key_release), 0);
        check({tag, "_long"},    int'(kif.key_long),    0);
        check({tag, "_repeat"},  int'(kif.key_repeat),  0);
        check({tag, "_held"},    int'(kif.key_held),    0);
    endtask

    // Monitor: every pulse consumes the head of the scoreboard; held follows windows.
    always @(negedge clk) begin
        logic [3:0] pv;
        ev_t        e;
        int         held_exp;
        if (!rst) begin
            held_exp = ((cyc >= p1 && cyc < r1) || (cyc >= p2 && cyc < r2)) ? 1 : 0;
            check("held_level", int'(kif.key_held), held_exp);
            pv = {kif.key_repeat, kif.key_long, kif.key_release, kif.key_press};
            for (int k = 0; k < 4; k++) begin
                if (pv[k] === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("spurious_pulse_kind", k, -1);
                    end else begin
                        e = sb.pop_front();
                        check("pulse_kind", k, e.kind);
                        check("pulse_cycle", cyc, e.at);
                    end
                end
            end
            $display("cycle %0d: in=%0b press=%0b rel=%0b long=%0b rep=%0b held=%0b",
                     cyc, kif.key_in, pv[0], pv[1], pv[2], pv[3], kif.key_held);
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        p1 = 0; r1 = 0; p2 = 0; r2 = 0;
        rst        = 1'b1;
        kif.key_in = 1'b1;

        at(3);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Clean short press
        t0 = 10;
        held_windows(t0 + 6, t0 + 16, 0, 0);
        push(0, t0 + 6);
        push(1, t0 + 16);
        at(t0);      kif.key_in = 1'b0;
        at(t0 + 10); kif.key_in = 1'b1;
        at(t0 + 30);
        check("short_drain", sb.size(), 0);

        // Press bounce: never DEB consecutive lows
        t0 = 50;
        held_windows(0, 0, 0, 0);
        at(t0);     kif.key_in = 1'b0;
        at(t0 + 3); kif.key_in = 1'b1;
        at(t0 + 4); kif.key_in = 1'b0;
        at(t0 + 6); kif.key_in = 1'b1;
        at(t0 + 25);
        check("bounce_drain", sb.size(), 0);
        check_idle_outputs("bounce");

        // Long hold with auto-repeat
        t0 = 90;
        held_windows(t0 + 6, t0 + 66, 0, 0);
        push(0, t0 + 6);
        push(2, t0 + 26);
        push(3, t0 + 34);
        push(3, t0 + 42);
        push(3, t0 + 50);
        push(3, t0 + 58);
        push(1, t0 + 66);
        at(t0);      kif.key_in = 1'b0;
        at(t0 + 60); kif.key_in = 1'b1;
        at(t0 + 80);
        check("long_drain", sb.size(), 0);

        // Release glitch freezes hold for two samples
        t0 = 190;
        held_windows(t0 + 6, t0 + 46, 0, 0);
        push(0, t0 + 6);
        push(2, t0 + 28);
        push(3, t0 + 36);
        push(1, t0 + 46);
        at(t0);      kif.key_in = 1'b0;
        at(t0 + 10); kif.key_in = 1'b1;
        at(t0 + 12); kif.key_in = 1'b0;
        at(t0 + 40); kif.key_in = 1'b1;
        at(t0 + 60);
        check("glitch_drain", sb.size(), 0);

        // Reset in LONG_HELD with key still low
        t0 = 260;
        held_windows(t0 + 6, t0 + 40, t0 + 46, t0 + 66);
        push(0, t0 + 6);
        push(2, t0 + 26);
        push(3, t0 + 34);
        push(0, t0 + 46);
        push(1, t0 + 66);
        at(t0);      kif.key_in = 1'b0;
        at(t0 + 39); rst = 1'b1;
        at(t0 + 40);
        check_idle_outputs("midreset");
        rst = 1'b0;
        at(t0 + 60); kif.key_in = 1'b1;
        at(t0 + 80);
        check("reset_drain", sb.size(), 0);

        // Release then immediate re-press
        t0 = 350;
        held_windows(t0 + 6, t0 + 16, t0 + 23, t0 + 36);
        push(0, t0 + 6);
        push(1, t0 + 16);
        push(0, t0 + 23);
        push(1, t0 + 36);
        at(t0);      kif.key_in = 1'b0;
        at(t0 + 10); kif.key_in = 1'b1;
        at(t0 + 17); kif.key_in = 1'b0;
        at(t0 + 30); kif.key_in = 1'b1;
        at(t0 + 50);
        check("repress_drain", sb.size(), 0);
        check_idle_outputs("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_event.md
Name: key_event

Overview:
- Press-and-release key event generator for the watch's setting buttons.
- Samples one raw active-low key and debounces both the press edge and the release edge.
- Emits single-cycle pulses for press, release, long-press and auto-repeat, plus a held level.
- Sits between the board key pins and the time-set/mode control logic, so the controllers can react to release and to long holds.

Parameters:
- DEB_CNT, 15: consecutive identical samples needed to accept a press or a release (≥2).
- LONG_CNT, 200: clocks a press must be held, after key_press, before key_long (≥2).
- REPEAT_CNT, 50: clocks between key_long and the first key_repeat, and between successive key_repeat pulses (≥2).
- CNT_W, 8: width of internal counters; must hold max(DEB_CNT, LONG_CNT, REPEAT_CNT).

Ports:
- key_clk  in  1  sampling clock (slow tick clock, same domain as the consumers).
- key_rst  in  1  reset, synchronous, active-high.
- key_in  in  1  raw key, active-low (0 = pressed), asynchronous.
- key_press  out  1  one-cycle pulse when a press is accepted.
- key_release  out  1  one-cycle pulse when a release is accepted.
- key_long  out  1  one-cycle pulse when the hold reaches LONG_CNT.
- key_repeat  out  1  one-cycle pulse every REPEAT_CNT clocks after key_long.
- key_held  out  1  level: 1 from key_press until key_release.

Behaviour:
- Clock and reset: one clock, key_clk. key_rst is synchronous and active-high.
- Input synchronizer: key_in passes through a 2-flop synchronizer (reset value 1). The FSM sees only the synchronizer output s.
- Reset values: all outputs 0, state IDLE, all counters 0. Reset applied mid-hold emits no key_release.
- All outputs are registered. Pulses are exactly 1 cycle wide.
- States: IDLE, PRESS_DEB, HELD, LONG_HELD, REL_DEB; flag lng records which held state was left.
- IDLE:
  - s=0 -> PRESS_DEB, deb=1.
  - s=1 -> stay.
- PRESS_DEB:
  - s=1 -> IDLE, deb=0 (bounce rejected).
  - s=0 -> deb+1.
  - On the DEB_CNT-th consecutive low: key_press=1, key_held=1, -> HELD, hold=0.
- HELD, each cycle with s=0: hold+1.
  - When hold reaches LONG_CNT: key_long=1, -> LONG_HELD, rep=0.
- LONG_HELD, each cycle with s=0: rep+1.
  - When rep reaches REPEAT_CNT: key_repeat=1, rep=0.
  - Repeats continue indefinitely.
- HELD or LONG_HELD with s=1: -> REL_DEB, rel=1, lng set accordingly. hold/rep do not advance on that cycle.
- REL_DEB:
  - s=1 -> rel+1. On the DEB_CNT-th consecutive high: key_release=1, key_held=0, -> IDLE.
  - s=0 -> back to HELD or LONG_HELD per lng, rel=0. hold/rep advance on that cycle.
  - Net effect: hold/rep are frozen only for high samples.
- Timing with clean edges:
  - key_press is high in cycle DEB_CNT+2 after key_in falls.
  - key_long is exactly LONG_CNT clocks after key_press, given no glitches.
  - key_repeat follows every REPEAT_CNT clocks.
  - key_release is DEB_CNT+2 clocks after key_in rises.
- Simultaneous events: press and release can never coincide. key_long and key_repeat never assert in the same cycle. No pulse is emitted during REL_DEB.
- Counters never wrap: each is cleared on the transition that consumes it.

Decomposition:
- Shared package key_pkg holds:
  - state encoding localparams (IDLE..REL_DEB);
  - default DEB_CNT/LONG_CNT/REPEAT_CNT constants, shared with the other key blocks.
- One natural sub-module: key_sync, a 2-flop synchronizer with reset value 1.
- The FSM and counters stay in key_event.

Test Plan (DEB_CNT=4, LONG_CNT=20, REPEAT_CNT=8, t=0 at key_in fall):
- Clean short press: key_in low for cycles 0..9, then high.
  -> key_press at t=6; key_held high from t=6 to t=16; key_release at t=16; no key_long.
- Press bounce: low 3, high 1, low 2, then high.
  -> no pulse on any output; key_held stays 0.
- Long hold: key_in low for cycles 0..59.
  -> press t=6, long t=26, repeat t=34, 42, 50, 58; release t=66; nothing else.
- Release glitch: key_in low from t=0 except high for 2 cycles at t=10..11.
  -> no key_release; key_held stays 1; key_long delayed to t=28.
- Reset mid-hold: key_rst high for 1 cycle at t=40 in LONG_HELD, key_in still low.
  -> all outputs 0 at the next edge; no key_release; new key_press exactly DEB_CNT+2 clocks after key_rst falls.
- Release then immediate re-press: release accepted, then key_in low again 1 cycle later.
  -> second key_press 6 clocks after the new fall; key_held toggles 1->0->1 with no overlap.
